iter_multiplier: RTL and testbench
==================================

// Module: iter_multiplier
// PURPOSE
//  Iterative shift-add integer multiplier; the converse of the iterative divider in the ALU.
//  Computes the 2W-bit product z = x*y, signed or unsigned per u, one partial product per clock.
//  Uses the same run/stall contract as the divider, so the CPU stalls identically on MUL and DIV.
// PARAMETERS
//  W    32   operand width; product is 2W bits; latency W+1 cycles
// PORTS
//  clk    in   1    clock; all state updates on posedge
//  rst    in   1    synchronous reset, active-high
//  run    in   1    held high by the CPU while MUL executes
//  u      in   1    1 = signed (two's complement) operands, 0 = unsigned
//  x      in   W    multiplicand; sampled at S==0 only
//  y      in   W    multiplier; used every step, hold stable while run
//  stall  out  1    CPU stall request (combinational)
//  z      out  2W   product; valid when run & ~stall
// BEHAVIOUR
//  Interface: one clock, clk; reset rst is synchronous and active-high.
//  State: step counter S[$clog2(W+2)-1:0]; product/shift register P[2W-1:0]; z = P.
//  Reset: S<=0, P<=0; hence z=0; stall = run (combinational, S==0).
//  stall = run & (S != W+1).
//  S: rst -> 0; else ~run -> 0; else S==W+1 -> hold (saturate); else S+1.
//  P update, priority order:
//   rst            -> 0
//   S==0           -> {W'b0, x}            (load; also every idle cycle with run low)
//   S==W+1         -> hold                 (z stable while CPU consumes result)
//   1<=S<=W (step) -> {sum[W:0], P[W-1:1]}
//  Step arithmetic (W+1 bits):
//   a   = P[0] ? y : 0
//   hi  = {u & P[2W-1], P[2W-1:W]}
//   ae  = {u & a[W-1], a}
//   sum = (u & S==W) ? hi - ae : hi + ae   (MSB of x carries weight -2^(W-1) when signed)
//  Latency: run rises with S==0 -> stall high W+1 cycles (S=0..W); z valid at S==W+1.
//  run dropped mid-op: operation abandoned, S->0 next cycle, P reloads; no residue.
//  rst mid-op: same as above plus P cleared; if run still high, restarts at S=0, full latency.
//  Back-to-back MULs: run must drop for >=1 cycle (S returns to 0) between operations.
//  x changes after S==0 have no effect; y/u changes during steps give undefined z.
//  Product is always exact: no overflow, no flags.
// STRUCTURE
//  Shared ALU package: W default, constant MUL_DONE = W+1, S width function.
//  One sub-module: mul_step (combinational W+1-bit add/sub of hi, ae, sign ext by u).
//  Top: counter, P register, stall logic.
// TESTING
//  u=0, x=7, y=6 -> stall high 33 cycles, then z=64'h2A, held while run high.
//  u=0, x=y=32'hFFFFFFFF -> z=64'hFFFFFFFE_00000001.
//  u=1, x=-3, y=5 -> z=64'hFFFFFFFF_FFFFFFF1; u=1, x=-3, y=-5 -> z=64'hF.
//  u=1, x=y=32'h80000000 -> z=64'h40000000_00000000; u=1, x=32'h80000000, y=1 -> z=64'hFFFFFFFF_80000000.
//  run dropped at S=10, re-raised with x=3, y=4 -> full 33-cycle stall, z=12; rst at S=20 with run high -> z=0 next cycle, restart, correct product.
//  Reset: rst for 2 cycles, run=0 -> z=0, stall=0; random signed/unsigned sweep vs. $signed/$unsigned reference model.

Source files
------------

// File: rtl/iter_multiplier_pkg.sv
// Shared multiplier constants and helpers: default operand width, the
// "result ready" step value, and the width of the step counter.
package iter_multiplier_pkg;

  localparam int W_DEF = 32;

  typedef enum logic [1:0] {
    PH_LOAD = 2'd0,
    PH_STEP = 2'd1,
    PH_HOLD = 2'd2
  } mul_phase_e;

  // Step value at which the product is complete and held.
  function automatic int mul_done(input int w);
    return w + 1;
  endfunction

  // Width of a counter that must reach w+1.
  function automatic int s_width(input int w);
    return $clog2(w + 2);
  endfunction

  localparam int MUL_DONE = mul_done(W_DEF);

endpackage

// File: rtl/iter_multiplier_mul_step.sv
// One shift-add step: adds or subtracts the selected partial product to the
// upper half of the product register, with sign extension when signed.
module iter_multiplier_mul_step #(
  parameter int W = 32
) (
  input  logic         u,
  input  logic         sub,
  input  logic [W-1:0] hi,
  input  logic [W-1:0] a,
  output logic [W:0]   sum
);

  logic [W:0] hi_ext;
  logic [W:0] a_ext;

  always_comb begin
    hi_ext = {u & hi[W-1], hi};
    a_ext  = {u & a[W-1], a};
    sum    = sub ? (hi_ext - a_ext) : (hi_ext + a_ext);
  end

endmodule

// File: rtl/iter_multiplier.sv
// Iterative signed/unsigned multiplier, one partial product per clock.
// Shares the run/stall handshake of the iterative divider.
module iter_multiplier
  import iter_multiplier_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           run,
  input  logic           u,
  input  logic [W-1:0]   x,
  input  logic [W-1:0]   y,
  output logic           stall,
  output logic [2*W-1:0] z
);

  localparam int            SW     = s_width(W);
  localparam logic [SW-1:0] S_DONE = SW'(mul_done(W));
  localparam logic [SW-1:0] S_LAST = SW'(W);

  logic [SW-1:0]  s_q, s_d;
  logic [2*W-1:0] p_q, p_d;
  mul_phase_e     phase;
  logic [W-1:0]   a;
  logic           sub;
  logic [W:0]     sum;

  always_comb begin
    phase = PH_STEP;
    if (s_q == '0) begin
      phase = PH_LOAD;
    end else if (s_q == S_DONE) begin
      phase = PH_HOLD;
    end
  end

  // The multiplicand MSB has weight -2^(W-1) when signed, so the last step subtracts.
  assign a   = p_q[0] ? y : '0;
  assign sub = u & (s_q == S_LAST);

  iter_multiplier_mul_step #(.W(W)) u_step (
    .u   (u),
    .sub (sub),
    .hi  (p_q[2*W-1:W]),
    .a   (a),
    .sum (sum)
  );

  always_comb begin
    s_d = s_q;
    p_d = p_q;
    if (!run) begin
      s_d = '0;
    end else if (phase != PH_HOLD) begin
      s_d = s_q + SW'(1);
    end
    case (phase)
      PH_LOAD: p_d = {{W{1'b0}}, x};
      PH_HOLD: p_d = p_q;
      default: p_d = {sum, p_q[W-1:1]};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s_q <= '0;
      p_q <= '0;
    end else begin
      s_q <= s_d;
      p_q <= p_d;
    end
  end

  assign stall = run & (s_q != S_DONE);
  assign z     = p_q;

endmodule

// File: tb/tb_iter_multiplier.sv
// Directed and random checks of the iterative multiplier: products, stall
// length, result hold, abort and mid-operation reset.
module tb_iter_multiplier;

  localparam int W = 32;

  logic           clk = 1'b0;
  logic           rst, run, u;
  logic [W-1:0]   x, y;
  logic           stall;
  logic [2*W-1:0] z;

  int checks = 0;
  int errors = 0;

  iter_multiplier #(.W(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .run   (run),
    .u     (u),
    .x     (x),
    .y     (y),
    .stall (stall),
    .z     (z)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic           u;
    logic [W-1:0]   x;
    logic [W-1:0]   y;
    logic [2*W-1:0] z;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at posedge+1 with run high; counts stall cycles up to the first
  // negedge where stall is low, leaving time at that negedge.
  task automatic wait_done(output int cnt);
    bit done;
    cnt  = 0;
    done = 0;
    for (int i = 0; i < 200 && !done; i++) begin
      @(negedge clk);
      if (stall) begin
        cnt++;
        @(posedge clk);
        #1;
      end else begin
        done = 1;
      end
    end
  endtask

  task automatic do_mul(input string name, input logic uu, input logic [W-1:0] xx,
                        input logic [W-1:0] yy, input logic [63:0] exp);
    int cnt;
    u   = uu;
    x   = xx;
    y   = yy;
    run = 1'b1;
    wait_done(cnt);
    $display("mul %s u=%0d x=%h y=%h z=%h stall_cycles=%0d", name, uu, xx, yy, z, cnt);
    check({name, " stall"}, 64'(cnt), 64'd33);
    check({name, " z"}, z, exp);
    @(posedge clk);
    #1;
    @(negedge clk);
    check({name, " hold"}, {z[62:0], stall}, {exp[62:0], 1'b0});
    @(posedge clk);
    #1;
    run = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int cnt;
    logic [W-1:0] rx, ry;
    logic         ru;
    logic [63:0]  rexp;

    vecs[0]  = '{1'b0, 32'd7,         32'd6,         64'h0000_0000_0000_002A};
    vecs[1]  = '{1'b0, 32'hFFFFFFFF,  32'hFFFFFFFF,  64'hFFFF_FFFE_0000_0001};
    vecs[2]  = '{1'b1, 32'hFFFFFFFD,  32'd5,         64'hFFFF_FFFF_FFFF_FFF1};
    vecs[3]  = '{1'b1, 32'hFFFFFFFD,  32'hFFFFFFFB,  64'h0000_0000_0000_000F};
    vecs[4]  = '{1'b1, 32'h80000000,  32'h80000000,  64'h4000_0000_0000_0000};
    vecs[5]  = '{1'b1, 32'h80000000,  32'd1,         64'hFFFF_FFFF_8000_0000};
    vecs[6]  = '{1'b0, 32'h80000000,  32'h80000000,  64'h4000_0000_0000_0000};
    vecs[7]  = '{1'b0, 32'd0,         32'h12345678,  64'h0000_0000_0000_0000};
    vecs[8]  = '{1'b1, 32'hFFFFFFFF,  32'hFFFFFFFF,  64'h0000_0000_0000_0001};
    vecs[9]  = '{1'b0, 32'hFFFFFFFF,  32'd2,         64'h0000_0001_FFFF_FFFE};
    vecs[10] = '{1'b1, 32'h7FFFFFFF,  32'h80000000,  64'hC000_0000_8000_0000};

    rst = 1'b1; run = 1'b0; u = 1'b0; x = '0; y = '0;
    @(posedge clk); @(posedge clk);
    #1;
    @(negedge clk);
    check("reset z", z, 64'd0);
    check("reset stall idle", 64'(stall), 64'd0);
    run = 1'b1;
    #1;
    check("reset stall run", 64'(stall), 64'd1);
    @(posedge clk);
    #1;
    run = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 11; i++) begin
      do_mul($sformatf("vec%0d", i), vecs[i].u, vecs[i].x, vecs[i].y, vecs[i].z);
    end

    // x is sampled only when the operation starts.
    u = 1'b0; x = 32'd11; y = 32'd13; run = 1'b1;
    for (int i = 0; i < 3; i++) begin @(posedge clk); #1; end
    x = 32'hDEADBEEF;
    wait_done(cnt);
    $display("mul late_x z=%h stall_cycles=%0d", z, cnt);
    check("late_x stall", 64'(cnt), 64'd30);
    check("late_x z", z, 64'd143);
    @(posedge clk); #1; run = 1'b0; @(posedge clk); #1;

    // Abort at S=10, then a fresh operation runs full length.
    u = 1'b0; x = 32'hABCDEF01; y = 32'h12345; run = 1'b1;
    for (int i = 0; i < 10; i++) begin @(posedge clk); #1; end
    run = 1'b0;
    @(posedge clk); #1;
    check("abort stall idle", 64'(stall), 64'd0);
    do_mul("after_abort", 1'b0, 32'd3, 32'd4, 64'd12);

    // Reset at S=20 with run held high restarts from scratch.
    u = 1'b0; x = 32'd5; y = 32'd9; run = 1'b1;
    for (int i = 0; i < 20; i++) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst z", z, 64'd0);
    check("midrst stall", 64'(stall), 64'd1);
    wait_done(cnt);
    $display("mul midrst z=%h stall_cycles=%0d", z, cnt);
    check("midrst restart stall", 64'(cnt), 64'd33);
    check("midrst restart z", z, 64'd45);
    @(posedge clk); #1; run = 1'b0; @(posedge clk); #1;

    for (int i = 0; i < 20; i++) begin
      ru = 1'($urandom_range(0, 1));
      rx = $urandom;
      ry = $urandom;
      if (ru) rexp = {{32{rx[31]}}, rx} * {{32{ry[31]}}, ry};
      else    rexp = {32'd0, rx} * {32'd0, ry};
      do_mul($sformatf("rnd%0d", i), ru, rx, ry, rexp);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
